// File: rtl/featuremap_channel_accumulator.sv
// featuremap_channel_accumulator
// Sums one output pixel's NUM_CH float32 channel results plus BIAS, serially
// through a single round-to-nearest-even adder in the fixed order
// ((BIAS+ch0)+ch1)+...+ch(NUM_CH-1). All lanes are popped together with rdreq.
// The result leaves through a valid/ready register stage.
// Build option: define FEATUREMAP_RELU_EN to clamp negative results
// (sign bit set) to +0.0.
module featuremap_channel_accumulator #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_CH     = 8,
    parameter logic [DATA_WIDTH-1:0] BIAS       = 32'h00000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic                         rdreq,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         busy
);

    localparam int               IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   acc;
    logic [DATA_WIDTH-1:0]   lane [NUM_CH];
    logic [DATA_WIDTH-1:0]   sum;

    // Single-precision add, round-to-nearest-even, subnormals kept.
    // NaN inputs or inf-inf give the canonical quiet NaN.
    // NOTE: locals inside a function use blocking '=': it is pure combinational
    // evaluation, every local is assigned before use, so no latch or state appears.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic        a_nan, b_nan, a_inf, b_inf, sub, sticky, rnd;
        logic [7:0]  ex, ey, d;
        logic [26:0] mx, my, mask;
        logic [27:0] s;
        logic [9:0]  e;
        logic [24:0] m;
        logic [31:0] r;
        a_nan = (&a[30:23]) & (|a[22:0]);
        b_nan = (&b[30:23]) & (|b[22:0]);
        a_inf = (&a[30:23]) & ~(|a[22:0]);
        b_inf = (&b[30:23]) & ~(|b[22:0]);
        // x is the operand of larger magnitude; it fixes the result sign
        if (a[30:0] >= b[30:0]) begin
            x = a; y = b;
        end else begin
            x = b; y = a;
        end
        ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        // hidden bit, 23 fraction bits, guard/round/sticky
        mx = {|x[30:23], x[22:0], 3'b000};
        my = {|y[30:23], y[22:0], 3'b000};
        d = ex - ey;
        mask = ~({27{1'b1}} << d);
        sticky = |(my & mask);
        my = (my >> d) | {26'd0, sticky};
        sub = x[31] ^ y[31];
        s = sub ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
        e = {2'b00, ex};
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!s[26] && (e > 10'd1) && (s != 28'd0)) begin
                    s = s << 1;
                    e = e - 10'd1;
                end
            end
        end
        rnd = s[2] & (s[1] | s[0] | s[3]);
        m = {1'b0, s[26:3]} + {24'd0, rnd};
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'd1;
        end
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31])))
            r = 32'h7FC00000;
        else if (a_inf || b_inf)
            r = {x[31], 8'hFF, 23'd0};
        else if (s == 28'd0)
            r = {sub ? 1'b0 : x[31], 31'd0};
        else if (e >= 10'd255)
            r = {x[31], 8'hFF, 23'd0};
        else
            r = {x[31], m[23] ? e[7:0] : 8'd0, m[22:0]};
        return r;
    endfunction

    // Output transform applied when the final sum is registered
    function automatic logic [DATA_WIDTH-1:0] post_op(input logic [DATA_WIDTH-1:0] v);
`ifdef FEATUREMAP_RELU_EN
        return v[DATA_WIDTH-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Pop all lanes only when every lane has data and the result slot is free
    assign rdreq = rst & (&in_valid) & ((state == IDLE) | ((state == OUT) & out_ready));
    assign busy  = (state != IDLE);
    assign sum   = fp_add(acc, lane[idx]);

    // Capture lanes, step the serial accumulation, hold the result under backpressure
    // NOTE: sequential state uses '<=' only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            // NOTE: the lane bank is a small register array, not RAM, so it can be cleared on reset.
            for (int i = 0; i < NUM_CH; i++) lane[i] <= '0;
        end else if (rdreq) begin
            for (int i = 0; i < NUM_CH; i++) lane[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
            acc       <= BIAS;
            idx       <= '0;
            out_valid <= 1'b0;
            state     <= ACCUM;
        end else begin
            case (state)
                ACCUM: begin
                    acc <= sum;
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        out_valid <= 1'b1;
                        out_data  <= post_op(sum);
                        state     <= OUT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
